// File: rtl/tcdm_rr_bank_arb_pkg.sv
// Shared TCDM interconnect definitions: master-index sizing and the
// cyclic round-robin increment used by the bank arbiters.
package tcdm_rr_bank_arb_pkg;

  localparam int unsigned NUM_MASTER_DEF = 16;
  localparam int unsigned MST_IDX_W_DEF  = (NUM_MASTER_DEF > 1) ? $clog2(NUM_MASTER_DEF) : 1;

  typedef logic [MST_IDX_W_DEF-1:0] mst_idx_t;

  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Wraps at n, not at the power of two above it.
  function automatic int unsigned rr_inc(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/tcdm_rr_bank_arb_rr_prio_sel.sv
// Combinational cyclic priority search: first set req bit at or above ptr,
// wrapping at N. Doubled-vector rotate followed by a leading-one scan.
module rr_prio_sel #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         vld
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W:0]     off;
  logic [W:0]     sum;

  assign dbl = {req, req};
  assign rot = N'(dbl >> ptr);
  assign vld = |req;

  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = (W+1)'(i);
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
    idx = vld ? sum[W-1:0] : ptr;
  end

endmodule

// File: rtl/tcdm_rr_bank_arb.sv
// Per-bank round-robin arbiter: picks one master per cycle, forwards its
// payload, returns the bank grant and tags the read response owner.
module tcdm_rr_bank_arb
  import tcdm_rr_bank_arb_pkg::*;
#(
  parameter int unsigned NumMaster     = 16,
  parameter int unsigned ReqDataWidth  = 32,
  parameter int unsigned RespDataWidth = 32,
  parameter int unsigned RespLat       = 1
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic [NumMaster-1:0]                        req_i,
  input  logic [NumMaster-1:0][ReqDataWidth-1:0]      data_i,
  output logic [NumMaster-1:0]                        gnt_o,
  output logic [NumMaster-1:0]                        rvld_o,
  output logic [NumMaster-1:0][RespDataWidth-1:0]     rdata_o,
  output logic                                        req_o,
  input  logic                                        gnt_i,
  output logic [ReqDataWidth-1:0]                     data_o,
  input  logic [RespDataWidth-1:0]                    rdata_i
);

  localparam int unsigned IdxW = idx_w(NumMaster);

  logic [IdxW-1:0]                  rr_q;
  logic [IdxW-1:0]                  winner;
  logic                             any_req;
  logic                             hs;
  logic [RespLat-1:0]               vld_pipe;
  logic [RespLat-1:0][IdxW-1:0]     idx_pipe;

  rr_prio_sel #(.N(NumMaster), .W(IdxW)) u_sel (
    .req (req_i),
    .ptr (rr_q),
    .idx (winner),
    .vld (any_req)
  );

  assign req_o   = any_req;
  assign hs      = any_req & gnt_i;
  assign rdata_o = {NumMaster{rdata_i}};

  always_comb begin
    gnt_o  = '0;
    rvld_o = '0;
    data_o = data_i[0];
    for (int m = 0; m < NumMaster; m++) begin
      if (winner == IdxW'(m)) begin
        gnt_o[m] = hs;
        data_o   = data_i[m];
      end
      rvld_o[m] = vld_pipe[RespLat-1] && (idx_pipe[RespLat-1] == IdxW'(m));
    end
  end

  // Pointer only moves on an accepted request so a denied grant keeps priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q     <= '0;
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe[0] <= hs;
      idx_pipe[0] <= winner;
      for (int s = 1; s < RespLat; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        idx_pipe[s] <= idx_pipe[s-1];
      end
      if (hs) rr_q <= IdxW'(rr_inc(32'(winner), NumMaster));
    end
  end

endmodule

// File: tb/tb_tcdm_rr_bank_arb.sv
// Scoreboard bench for tcdm_rr_bank_arb: three configurations
// (4 masters/lat 1, 5 masters/lat 3, 4 masters/lat 2) exercised one at a time.
module tb_tcdm_rr_bank_arb;

  localparam logic [31:0] RB = 32'hD000_0000;

  typedef struct {
    int          d;
    logic [4:0]  v;
    logic [31:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] rdata;

  logic [3:0]        req_a, gnt_oa, rvld_a;
  logic [3:0][31:0]  data_a, rdata_oa;
  logic              req_oa, gnt_ia;
  logic [31:0]       data_oa;

  logic [4:0]        req_b, gnt_ob, rvld_b;
  logic [4:0][31:0]  data_b, rdata_ob;
  logic              req_ob, gnt_ib;
  logic [31:0]       data_ob;

  logic [3:0]        req_c, gnt_oc, rvld_c;
  logic [3:0][31:0]  data_c, rdata_oc;
  logic              req_oc, gnt_ic;
  logic [31:0]       data_oc;

  tcdm_rr_bank_arb #(.NumMaster(4), .ReqDataWidth(32), .RespDataWidth(32), .RespLat(1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .data_i(data_a), .gnt_o(gnt_oa),
    .rvld_o(rvld_a), .rdata_o(rdata_oa), .req_o(req_oa), .gnt_i(gnt_ia),
    .data_o(data_oa), .rdata_i(rdata));

  tcdm_rr_bank_arb #(.NumMaster(5), .ReqDataWidth(32), .RespDataWidth(32), .RespLat(3)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .data_i(data_b), .gnt_o(gnt_ob),
    .rvld_o(rvld_b), .rdata_o(rdata_ob), .req_o(req_ob), .gnt_i(gnt_ib),
    .data_o(data_ob), .rdata_i(rdata));

  tcdm_rr_bank_arb #(.NumMaster(4), .ReqDataWidth(32), .RespDataWidth(32), .RespLat(2)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_c), .data_i(data_c), .gnt_o(gnt_oc),
    .rvld_o(rvld_c), .rdata_o(rdata_oc), .req_o(req_oc), .gnt_i(gnt_ic),
    .data_o(data_oc), .rdata_i(rdata));

  logic [4:0]  gnt_w [3];
  logic [4:0]  rvld_w [3];
  logic [31:0] dat_w [3];
  logic [31:0] rd0_w [3];
  logic [31:0] rdl_w [3];

  assign gnt_w[0]  = {1'b0, gnt_oa};   assign gnt_w[1]  = gnt_ob;   assign gnt_w[2]  = {1'b0, gnt_oc};
  assign rvld_w[0] = {1'b0, rvld_a};   assign rvld_w[1] = rvld_b;   assign rvld_w[2] = {1'b0, rvld_c};
  assign dat_w[0]  = data_oa;          assign dat_w[1]  = data_ob;  assign dat_w[2]  = data_oc;
  assign rd0_w[0]  = rdata_oa[0];      assign rd0_w[1]  = rdata_ob[0]; assign rd0_w[2] = rdata_oc[0];
  assign rdl_w[0]  = rdata_oa[3];      assign rdl_w[1]  = rdata_ob[4]; assign rdl_w[2] = rdata_oc[3];

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t gq[$];
  exp_t rq[$];
  exp_t e;

  function automatic logic [31:0] payload(int d, int m, int c);
    return {4'(d), 4'(m), 24'(c)};
  endfunction

  function automatic int oh2idx(logic [4:0] v);
    int r = 0;
    for (int i = 0; i < 5; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic int lat(int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  // One cycle on DUT d; eg is the expected grant, track queues its response.
  task automatic step(input int d, input logic [4:0] rv, input logic g,
                      input logic [4:0] eg, input bit track);
    exp_t x;
    if (eg != 5'd0) begin
      x.d = d; x.v = eg; x.dat = payload(d, oh2idx(eg), cyc);
      gq.push_back(x);
      if (track) begin
        x.dat = RB + 32'(cyc + lat(d));
        rq.push_back(x);
      end
    end
    req_a  = (d == 0) ? rv[3:0] : 4'd0;
    req_b  = (d == 1) ? rv      : 5'd0;
    req_c  = (d == 2) ? rv[3:0] : 4'd0;
    gnt_ia = (d == 0) ? g : 1'b0;
    gnt_ib = (d == 1) ? g : 1'b0;
    gnt_ic = (d == 2) ? g : 1'b0;
    for (int m = 0; m < 4; m++) begin
      data_a[m] = payload(0, m, cyc);
      data_c[m] = payload(2, m, cyc);
    end
    for (int m = 0; m < 5; m++) data_b[m] = payload(1, m, cyc);
    rdata = RB + 32'(cyc);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (gnt_w[d] != 5'd0) begin
        checks++;
        if (gq.size() == 0) begin
          errors++;
          $display("FAIL gnt_unexpected dut%0d got gnt=%b exp none", d, gnt_w[d]);
        end else begin
          e = gq.pop_front();
          if (e.d != d || e.v != gnt_w[d] || e.dat != dat_w[d]) begin
            errors++;
            $display("FAIL gnt dut%0d got gnt=%b data=%h exp dut%0d gnt=%b data=%h",
                     d, gnt_w[d], dat_w[d], e.d, e.v, e.dat);
          end
        end
      end
      if (rvld_w[d] != 5'd0) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL rvld_unexpected dut%0d got rvld=%b exp none", d, rvld_w[d]);
        end else begin
          e = rq.pop_front();
          if (e.d != d || e.v != rvld_w[d] || e.dat != rd0_w[d] || e.dat != rdl_w[d]) begin
            errors++;
            $display("FAIL rvld dut%0d got rvld=%b rdata=%h/%h exp dut%0d rvld=%b rdata=%h",
                     d, rvld_w[d], rd0_w[d], rdl_w[d], e.d, e.v, e.dat);
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] pend;
    int         waits [4];
    int         mrr, w, c;
    logic       g;
    logic [4:0] eg;

    rst_n = 1'b0;
    step(0, 5'd0, 1'b0, 5'd0, 0);
    chk("rst_rvld_a", 32'(rvld_a), 32'd0);
    chk("rst_rvld_b", 32'(rvld_b), 32'd0);
    chk("rst_rvld_c", 32'(rvld_c), 32'd0);
    chk("rst_req_o",  32'(req_oa), 32'd0);
    rst_n = 1'b1;
    step(0, 5'd0, 1'b0, 5'd0, 0);

    // All four request continuously: strict rotation, responses one cycle later.
    for (int k = 0; k < 8; k++) step(0, 5'b01111, 1'b1, 5'(1) << (k % 4), 1);
    repeat (2) step(0, 5'd0, 1'b0, 5'd0, 0);

    // Denied grants do not move the pointer.
    step(0, 5'b01010, 1'b0, 5'd0, 0);
    chk("req_o_no_gnt", 32'(req_oa), 32'd1);
    chk("gnt_denied",   32'(gnt_oa), 32'd0);
    step(0, 5'b01010, 1'b0, 5'd0, 0);
    step(0, 5'b01010, 1'b0, 5'd0, 0);
    step(0, 5'b01010, 1'b1, 5'b00010, 1);
    step(0, 5'b01111, 1'b1, 5'b00100, 1);
    step(0, 5'b01111, 1'b1, 5'b01000, 1);
    step(0, 5'b01111, 1'b1, 5'b00001, 1);
    repeat (2) step(0, 5'd0, 1'b0, 5'd0, 0);

    // Five masters: pointer wraps to 0 after master 4.
    step(1, 5'b10000, 1'b1, 5'b10000, 1);
    step(1, 5'b10001, 1'b1, 5'b00001, 1);
    // Latency 3, back-to-back owners 2, 0, 1.
    step(1, 5'b00100, 1'b1, 5'b00100, 1);
    step(1, 5'b00001, 1'b1, 5'b00001, 1);
    step(1, 5'b00010, 1'b1, 5'b00010, 1);
    repeat (5) step(1, 5'd0, 1'b0, 5'd0, 0);

    // Reset while a response is in flight: it must never surface.
    step(2, 5'b00100, 1'b1, 5'b00100, 0);
    rst_n = 1'b0;
    chk("midrst_rvld_c", 32'(rvld_c), 32'd0);
    step(2, 5'd0, 1'b0, 5'd0, 0);
    rst_n = 1'b1;
    repeat (3) step(2, 5'd0, 1'b0, 5'd0, 0);
    step(2, 5'b01111, 1'b1, 5'b00001, 1);
    repeat (3) step(2, 5'd0, 1'b0, 5'd0, 0);

    // Random sticky requests with a reference round-robin model.
    rst_n = 1'b0;
    step(0, 5'd0, 1'b0, 5'd0, 0);
    rst_n = 1'b1;
    pend = '0;
    mrr  = 0;
    for (int m = 0; m < 4; m++) waits[m] = 0;
    for (int n = 0; n < 10000; n++) begin
      for (int m = 0; m < 4; m++) if (!pend[m] && $urandom_range(0, 1) == 1) pend[m] = 1'b1;
      g = ($urandom_range(0, 3) != 0);
      w = -1;
      for (int i = 0; i < 4; i++) begin
        c = (mrr + i) % 4;
        if (pend[c] && w < 0) w = c;
      end
      eg = (g && w >= 0) ? (5'(1) << w) : 5'd0;
      step(0, {1'b0, pend}, g, eg, 1);
      if (eg != 5'd0) begin
        for (int m = 0; m < 4; m++) begin
          if (m != w && pend[m]) begin
            waits[m]++;
            chk("starvation", 32'(waits[m] < 4), 32'd1);
          end
        end
        pend[w]  = 1'b0;
        waits[w] = 0;
        mrr      = (w + 1) % 4;
      end
    end
    repeat (4) step(0, 5'd0, 1'b0, 5'd0, 0);

    chk("gnt_queue_drained",  32'(gq.size()), 32'd0);
    chk("rvld_queue_drained", 32'(rq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
